prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 29 ++
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, word/length sizing.
// LOADER_CHECKSUM_EN adds the CSUM state and the trailing checksum byte.
package prog_loader_pkg;

    localparam int WORD_W      = 16;
    localparam int LEN_BYTES   = 2;
    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        WRITE   = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        CSUM    = 3'd5,
`endif
        DONE    = 3'd6,
        ERR     = 3'd7
    } state_t;

    // Where a load goes once the last word (or an empty program) is through.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = CSUM;
`else
    localparam state_t LOAD_END = DONE;
`endif

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: length-prefixed 16-bit words into instruction memory,
// holding the CPU in reset until done. Optional checksum via LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int LEN_W = LEN_BYTES * 8;
    // One extra index bit so a full-depth load counts to 2^ADDR_W without wrapping.
    localparam int IDX_W = ADDR_W + 1;
    localparam int CMP_W = (IDX_W > LEN_W) ? IDX_W : LEN_W;
    localparam logic [CMP_W-1:0] MAX_WORDS = CMP_W'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  len_q;
    logic [7:0]        hi_q, lo_q;
    logic              accept, restart;
    logic [LEN_W-1:0]  len_in;
    logic [IDX_W-1:0]  idx_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
    logic [7:0]        csum_next;

    assign csum_next = csum_q + rx_data;
`endif

    assign accept  = rx_valid && rx_ready;
    assign restart = start && (state_q == DONE || state_q == ERR);
    assign len_in  = {len_q[LEN_W-1:8], rx_data};
    assign idx_inc = idx_q + 1'b1;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        case (state_q)
            LEN_HI: begin
                rx_ready = 1'b1;
                if (accept) state_d = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (accept) begin
                    if (len_in == '0)                      state_d = LOAD_END;
                    else if (CMP_W'(len_in) > MAX_WORDS)   state_d = ERR;
                    else                                   state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                rx_ready = 1'b1;
                if (accept) state_d = DATA_LO;
            end
            DATA_LO: begin
                rx_ready = 1'b1;
                if (accept) state_d = WRITE;
            end
            WRITE: begin
                if (CMP_W'(idx_inc) < CMP_W'(len_q)) state_d = DATA_HI;
                else                                 state_d = LOAD_END;
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                if (accept) state_d = (csum_next == 8'h00) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (start) state_d = LEN_HI;
            end
            default: state_d = LEN_HI;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LEN_HI;
            idx_q   <= '0;
            len_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (restart) begin
                idx_q  <= '0;
                len_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q <= '0;
`endif
            end else begin
                if (accept) begin
                    case (state_q)
                        LEN_HI:  len_q[LEN_W-1:8] <= rx_data;
                        LEN_LO:  len_q            <= len_in;
                        DATA_HI: hi_q             <= rx_data;
                        DATA_LO: lo_q             <= rx_data;
                        default: ;
                    endcase
                end
`ifdef LOADER_CHECKSUM_EN
                if (accept && state_q != CSUM) csum_q <= csum_next;
`endif
                if (state_q == WRITE) idx_q <= idx_inc;
            end
        end
    end

    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = idx_q[ADDR_W-1:0];
    assign imem_wdata = {hi_q, lo_q};
    assign cpu_reset  = (state_q != DONE);
    assign busy       = (state_q != DONE) && (state_q != ERR);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of byte streams plus hand-written
// reset/start corner sequences. Follows LOADER_CHECKSUM_EN if defined.
module tb_prog_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              start;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W+15:0] wr_q[$];

    typedef struct {
        int              nbytes;
        logic [0:7][7:0] bytes;
        int              gap;
        logic            exp_done;
        logic            exp_err;
        int              nwr;
        logic [0:3][15:0] wdata;
    } vec_t;

    vec_t vecs[6];

    prog_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Record every write strobe; cpu_reset must always be the inverse of done.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
            check("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cyc = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int cyc = 0;
        while (!(done || error) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!(done || error)) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: done=%0b error=%0b expected one set", name, done, error);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_writes(input string name, input int nwr, input logic [0:3][15:0] wdata);
        check($sformatf("%s_nwr", name), wr_q.size(), nwr);
        for (int i = 0; i < nwr && i < wr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), {24'd0, wr_q[i][ADDR_W+15:16]}, i);
            check($sformatf("%s_data%0d", name, i), {16'd0, wr_q[i][15:0]}, {16'd0, wdata[i]});
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        wr_q.delete();
        for (int i = 0; i < v.nbytes; i++) send_byte(v.bytes[i], v.gap);
`ifdef LOADER_CHECKSUM_EN
        if (v.exp_done) begin
            logic [7:0] sum;
            sum = 8'h00;
            for (int i = 0; i < v.nbytes; i++) sum = sum + v.bytes[i];
            send_byte(8'h00 - sum, v.gap);
        end
`endif
        wait_end(nm);
        repeat (2) @(negedge clk);
        check({nm, "_done"},      {31'd0, done},      {31'd0, v.exp_done});
        check({nm, "_error"},     {31'd0, error},     {31'd0, v.exp_err});
        check({nm, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~v.exp_done});
        check({nm, "_busy"},      {31'd0, busy},      32'd0);
        check_writes(nm, v.nwr, v.wdata);
    endtask

    task automatic check_restarted(input string name);
        check({name, "_busy"},      {31'd0, busy},      32'd1);
        check({name, "_done"},      {31'd0, done},      32'd0);
        check({name, "_error"},     {31'd0, error},     32'd0);
        check({name, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({name, "_rx_ready"},  {31'd0, rx_ready},  32'd1);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
        check({name, "_busy"},      {31'd0, busy},      32'd1);
        check({name, "_done"},      {31'd0, done},      32'd0);
        check({name, "_error"},     {31'd0, error},     32'd0);
        check({name, "_imem_we"},   {31'd0, imem_we},   32'd0);
        check({name, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
        check({name, "_imem_wdata"},{16'd0, imem_wdata},32'd0);
        check({name, "_rx_ready"},  {31'd0, rx_ready},  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{6, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00}, 0, 1'b1, 1'b0, 2,
                    {16'h1234, 16'hABCD, 16'h0000, 16'h0000}};
        vecs[1] = '{6, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00}, 3, 1'b1, 1'b0, 2,
                    {16'h1234, 16'hABCD, 16'h0000, 16'h0000}};
        vecs[2] = '{2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b1, 1'b0, 0,
                    {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[3] = '{2, {8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 0,
                    {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[4] = '{8, {8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01}, 0, 1'b1, 1'b0, 3,
                    {16'hDEAD, 16'hBEEF, 16'h0001, 16'h0000}};
        vecs[5] = '{4, {8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1'b0, 1,
                    {16'hFFFF, 16'h0000, 16'h0000, 16'h0000}};

        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], k);
            pulse_start();
            check_restarted($sformatf("v%0d_restart", k));
        end

        // start while in DATA_LO must not disturb the load
        wr_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        pulse_start();
        check("start_ign_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("start_ign_busy",     {31'd0, busy},     32'd1);
        send_byte(8'h34, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 - 8'h47, 0);
`endif
        wait_end("start_ign");
        check("start_ign_done", {31'd0, done}, 32'd1);
        check_writes("start_ign", 1, {16'h1234, 16'h0000, 16'h0000, 16'h0000});
        pulse_start();

        // reset in the middle of a load aborts it without a write
        wr_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_write", wr_q.size(), 0);
        check("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        run_vec(vecs[0], 10);
        pulse_start();

`ifdef LOADER_CHECKSUM_EN
        begin
            logic [0:3][15:0] w;
            w = {16'h1234, 16'h0000, 16'h0000, 16'h0000};
            wr_q.delete();
            send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
            send_byte(8'h34, 0); send_byte(8'hB9, 0);
            wait_end("csum_ok");
            check("csum_ok_done", {31'd0, done}, 32'd1);
            check_writes("csum_ok", 1, w);
            pulse_start();
            wr_q.delete();
            send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h12, 0);
            send_byte(8'h34, 0); send_byte(8'hB8, 0);
            wait_end("csum_bad");
            check("csum_bad_error", {31'd0, error}, 32'd1);
            check("csum_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
            pulse_start();
            check_restarted("csum_restart");
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
